pdl_ctrl: RTL and testbench

Sequencer and configuration controller for a bank of OUT_NUM pulse-delay-line channels. It holds the per-channel delay and width words in shadow registers written through a valid/ready port, and commits them atomically to active registers only while idle. On an armed external trigger edge it drives a programmable burst of trigger windows (high for on_cycles, low for off_cycles, shot_count times) to every enabled channel. The block sits between the host configuration bus and the pdl instances.

---
 rtl/pdl_ctrl_if.sv | 21 ++
 rtl/pdl_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_pdl_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdl_ctrl_if.sv
// Host configuration port for pdl_ctrl: valid/ready register writes plus an
// error pulse for writes that hit no register.
interface pdl_ctrl_if #(
   parameter int N = 32
);
   logic         cfg_valid;
   logic         cfg_ready;
   logic [7:0]   cfg_addr;
   logic [N-1:0] cfg_data;
   logic         cfg_err;

   modport master (
      output cfg_valid, cfg_addr, cfg_data,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_addr, cfg_data,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/pdl_ctrl.sv
// Pulse-delay-line sequencer: shadow/active configuration with atomic commit,
// and a trigger-started burst of on/off windows to every enabled channel.
module pdl_ctrl #(
   parameter int N       = 32,
   parameter int OUT_NUM = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   pdl_ctrl_if.slave            cfg,
   input  logic                 commit,
   input  logic                 arm,
   input  logic                 abort,
   input  logic                 ext_trigger,
   output logic [OUT_NUM-1:0]   ch_trigger,
   output logic [OUT_NUM*N-1:0] ch_dl,
   output logic [OUT_NUM*N-1:0] ch_wb,
   output logic                 busy,
   output logic                 commit_pending,
   output logic                 done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_TRIG,
      S_ON,
      S_OFF
   } state_t;

   state_t state, state_next;

   logic [N-1:0]       sh_dl  [OUT_NUM];
   logic [N-1:0]       sh_wb  [OUT_NUM];
   logic [OUT_NUM-1:0] sh_mask;
   logic [N-1:0]       sh_on, sh_off, sh_shots;

   logic [N-1:0]       act_dl [OUT_NUM];
   logic [N-1:0]       act_wb [OUT_NUM];
   logic [OUT_NUM-1:0] act_mask;
   logic [N-1:0]       act_on, act_off, act_shots;

   logic [N-1:0] timer, timer_next;
   logic [N-1:0] shot, shot_next;
   logic         done_next;
   logic         do_copy;
   logic         sync1, sync2, rise;

   logic wr_en, idx_ok, hit_dl, hit_wb, hit_mask, hit_on, hit_off, hit_shots, hit_any;

   function automatic logic [N-1:0] clamp1(input logic [N-1:0] v);
      return (v == '0) ? N'(1) : v;
   endfunction

   // Address decode
   always_comb begin
      wr_en     = cfg.cfg_valid & cfg.cfg_ready;
      idx_ok    = {1'b0, cfg.cfg_addr[5:0]} < 7'(OUT_NUM);
      hit_dl    = (cfg.cfg_addr[7:6] == 2'b00) && idx_ok;
      hit_wb    = (cfg.cfg_addr[7:6] == 2'b01) && idx_ok;
      hit_mask  = (cfg.cfg_addr == 8'h80);
      hit_on    = (cfg.cfg_addr == 8'h81);
      hit_off   = (cfg.cfg_addr == 8'h82);
      hit_shots = (cfg.cfg_addr == 8'h83);
      hit_any   = hit_dl | hit_wb | hit_mask | hit_on | hit_off | hit_shots;
   end

   // NOTE: registered state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking (=) here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg.cfg_ready <= 1'b0;
         cfg.cfg_err   <= 1'b0;
      end else begin
         cfg.cfg_ready <= 1'b1;
         cfg.cfg_err   <= wr_en & ~hit_any;
      end
   end

   // NOTE: these arrays are reset in full because their reset contents are
   // visible on ch_dl/ch_wb; plain storage without a defined reset value
   // should be left out of the reset branch.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < OUT_NUM; k++) begin
            sh_dl[k] <= '0;
            sh_wb[k] <= '0;
         end
         sh_mask  <= '0;
         sh_on    <= N'(1);
         sh_off   <= N'(1);
         sh_shots <= N'(1);
      end else if (wr_en) begin
         for (int k = 0; k < OUT_NUM; k++) begin
            if (hit_dl && cfg.cfg_addr[5:0] == 6'(k)) sh_dl[k] <= cfg.cfg_data;
            if (hit_wb && cfg.cfg_addr[5:0] == 6'(k)) sh_wb[k] <= cfg.cfg_data;
         end
         if (hit_mask) begin
            sh_mask <= '0;
            for (int i = 0; i < OUT_NUM && i < N; i++) sh_mask[i] <= cfg.cfg_data[i];
         end
         if (hit_on)    sh_on    <= cfg.cfg_data;
         if (hit_off)   sh_off   <= cfg.cfg_data;
         if (hit_shots) sh_shots <= cfg.cfg_data;
      end
   end

   // A commit outside IDLE is held until the cycle the FSM lands back in IDLE
   assign do_copy = (state == S_IDLE) ? commit
                                      : ((commit | commit_pending) && state_next == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < OUT_NUM; k++) begin
            act_dl[k] <= '0;
            act_wb[k] <= '0;
         end
         act_mask       <= '0;
         act_on         <= N'(1);
         act_off        <= N'(1);
         act_shots      <= N'(1);
         commit_pending <= 1'b0;
      end else begin
         if (do_copy) begin
            act_dl    <= sh_dl;
            act_wb    <= sh_wb;
            act_mask  <= sh_mask;
            act_on    <= sh_on;
            act_off   <= sh_off;
            act_shots <= sh_shots;
         end
         if (do_copy)     commit_pending <= 1'b0;
         else if (commit) commit_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= ext_trigger;
         sync2 <= sync1;
      end
   end

   assign rise = sync1 & ~sync2;

   // NOTE: every variable driven here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      timer_next = timer;
      shot_next  = shot;
      done_next  = 1'b0;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (arm) begin
                  if (act_mask == '0) done_next  = 1'b1;
                  else                state_next = S_WAIT_TRIG;
               end
            end
            S_WAIT_TRIG: begin
               if (rise) begin
                  state_next = S_ON;
                  shot_next  = clamp1(act_shots);
                  timer_next = clamp1(act_on);
               end
            end
            S_ON: begin
               if (timer == N'(1)) begin
                  if (shot == N'(1)) begin
                     state_next = S_IDLE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = S_OFF;
                     timer_next = clamp1(act_off);
                  end
               end else begin
                  timer_next = timer - N'(1);
               end
            end
            S_OFF: begin
               if (timer == N'(1)) begin
                  state_next = S_ON;
                  shot_next  = shot - N'(1);
                  timer_next = clamp1(act_on);
               end else begin
                  timer_next = timer - N'(1);
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         timer      <= '0;
         shot       <= '0;
         done       <= 1'b0;
         ch_trigger <= '0;
      end else begin
         state      <= state_next;
         timer      <= timer_next;
         shot       <= shot_next;
         done       <= done_next;
         ch_trigger <= (state_next == S_ON) ? act_mask : '0;
      end
   end

   assign busy = (state != S_IDLE);

   for (genvar k = 0; k < OUT_NUM; k++) begin : g_pack
      assign ch_dl[k*N +: N] = act_dl[k];
      assign ch_wb[k*N +: N] = act_wb[k];
   end

endmodule

// File: tb/tb_pdl_ctrl.sv
// Directed self-checking bench for pdl_ctrl: table-driven config writes plus
// hand-written burst, deferred-commit, abort and reset sequences.
module tb_pdl_ctrl;
   localparam int N       = 32;
   localparam int OUT_NUM = 8;

   logic clk, reset, commit, arm, abort, ext_trigger;
   logic [OUT_NUM-1:0]   ch_trigger;
   logic [OUT_NUM*N-1:0] ch_dl, ch_wb;
   logic busy, commit_pending, done;

   pdl_ctrl_if #(.N(N)) cfg_if ();

   pdl_ctrl #(.N(N), .OUT_NUM(OUT_NUM)) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg            (cfg_if.slave),
      .commit         (commit),
      .arm            (arm),
      .abort          (abort),
      .ext_trigger    (ext_trigger),
      .ch_trigger     (ch_trigger),
      .ch_dl          (ch_dl),
      .ch_wb          (ch_wb),
      .busy           (busy),
      .commit_pending (commit_pending),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        exp_err;
   } wr_vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0]          exp_dl [OUT_NUM];
   logic [31:0]          exp_wb [OUT_NUM];
   logic [OUT_NUM*N-1:0] exp_dl_p, exp_wb_p;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_addr  = a;
      cfg_if.cfg_data  = d;
      step();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   // Arms, triggers and follows one burst cycle by cycle; returns after the
   // cycle in which done goes low again.
   task automatic run_burst(input string nm, input logic [7:0] m, input int on_c,
                            input int off_c, input int shots, input int commit_at,
                            input bit retrig, input logic [31:0] dl_run,
                            input logic [31:0] dl_end);
      int oc, fc, sc, cyc;
      oc  = (on_c  == 0) ? 1 : on_c;
      fc  = (off_c == 0) ? 1 : off_c;
      sc  = (shots == 0) ? 1 : shots;
      cyc = 0;
      arm = 1'b1;
      step();
      arm = 1'b0;
      check({nm, ".busy_after_arm"}, 256'(busy), 256'(1));
      ext_trigger = 1'b1;
      step();
      check({nm, ".sync_delay"}, 256'(ch_trigger), 256'(0));
      for (int s = 0; s < sc; s++) begin
         for (int i = 0; i < oc; i++) begin
            if (cyc == commit_at) commit = 1'b1;
            step();
            commit = 1'b0;
            check($sformatf("%s.on[%0d][%0d]", nm, s, i), 256'(ch_trigger), 256'(m));
            if (commit_at >= 0 && cyc == commit_at)
               check({nm, ".pending_set"}, 256'(commit_pending), 256'(1));
            cyc++;
         end
         if (s < sc - 1) begin
            for (int i = 0; i < fc; i++) begin
               if (retrig) ext_trigger = ~ext_trigger;
               step();
               check($sformatf("%s.off[%0d][%0d]", nm, s, i), 256'(ch_trigger), 256'(0));
               cyc++;
            end
         end
      end
      check({nm, ".dl_during_run"}, 256'(ch_dl[31:0]), 256'(dl_run));
      ext_trigger = 1'b0;
      step();
      check({nm, ".done_pulse"}, 256'(done), 256'(1));
      check({nm, ".busy_end"}, 256'(busy), 256'(0));
      check({nm, ".trig_end"}, 256'(ch_trigger), 256'(0));
      check({nm, ".pending_end"}, 256'(commit_pending), 256'(0));
      check({nm, ".dl_end"}, 256'(ch_dl[31:0]), 256'(dl_end));
      step();
      check({nm, ".done_once"}, 256'(done), 256'(0));
   endtask

   wr_vec_t vec [10];

   initial begin
      vec[0] = '{8'h00, 32'd100,      1'b0};
      vec[1] = '{8'h40, 32'd50,       1'b0};
      vec[2] = '{8'h80, 32'h01,       1'b0};
      vec[3] = '{8'h07, 32'd7,        1'b0};
      vec[4] = '{8'h47, 32'd77,       1'b0};
      vec[5] = '{8'h48, 32'hDEAD,     1'b1};
      vec[6] = '{8'h08, 32'hBEEF,     1'b1};
      vec[7] = '{8'h84, 32'd9,        1'b1};
      vec[8] = '{8'hFF, 32'd9,        1'b1};
      vec[9] = '{8'h3F, 32'd5,        1'b1};
      for (int k = 0; k < OUT_NUM; k++) begin
         exp_dl[k] = '0;
         exp_wb[k] = '0;
      end

      reset = 1'b1; commit = 1'b0; arm = 1'b0; abort = 1'b0; ext_trigger = 1'b0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
      repeat (3) step();
      check("rst.cfg_ready", 256'(cfg_if.cfg_ready), 256'(0));
      check("rst.ch_trigger", 256'(ch_trigger), 256'(0));
      check("rst.busy_done", 256'({busy, done, commit_pending, cfg_if.cfg_err}), 256'(0));
      check("rst.ch_dl", 256'(ch_dl), 256'(0));
      reset = 1'b0;
      step();
      check("rst.cfg_ready_rise", 256'(cfg_if.cfg_ready), 256'(1));

      // Arm with an all-zero mask: no run, but done still pulses
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("mask0.done", 256'(done), 256'(1));
      check("mask0.busy", 256'(busy), 256'(0));
      step();
      check("mask0.done_low", 256'(done), 256'(0));

      foreach (vec[i]) begin
         cfg_write(vec[i].addr, vec[i].data);
         check($sformatf("cfg_err[%0d]", i), 256'(cfg_if.cfg_err), 256'(vec[i].exp_err));
         if (!vec[i].exp_err && vec[i].addr < 8'h40) exp_dl[vec[i].addr[5:0]] = vec[i].data;
         if (!vec[i].exp_err && vec[i].addr[7:6] == 2'b01) exp_wb[vec[i].addr[5:0]] = vec[i].data;
      end
      check("shadow_only.ch_dl", 256'(ch_dl), 256'(0));
      do_commit();
      for (int k = 0; k < OUT_NUM; k++) begin
         exp_dl_p[k*N +: N] = exp_dl[k];
         exp_wb_p[k*N +: N] = exp_wb[k];
      end
      check("commit.ch_dl", 256'(ch_dl), 256'(exp_dl_p));
      check("commit.ch_wb", 256'(ch_wb), 256'(exp_wb_p));

      // Write and commit together: commit takes the pre-write shadow
      commit = 1'b1;
      cfg_write(8'h02, 32'h55);
      commit = 1'b0;
      check("same_cycle.old", 256'(ch_dl[2*N +: N]), 256'(0));
      do_commit();
      check("same_cycle.new", 256'(ch_dl[2*N +: N]), 256'(32'h55));

      cfg_write(8'h80, 32'h05);
      cfg_write(8'h81, 32'd4);
      cfg_write(8'h82, 32'd2);
      cfg_write(8'h83, 32'd3);
      do_commit();
      run_burst("basic", 8'h05, 4, 2, 3, -1, 1'b0, 32'd100, 32'd100);

      cfg_write(8'h80, 32'hFF);
      cfg_write(8'h00, 32'h123);
      run_burst("defer", 8'h05, 4, 2, 3, 2, 1'b0, 32'd100, 32'h123);
      run_burst("newmask", 8'hFF, 4, 2, 3, -1, 1'b0, 32'h123, 32'h123);

      // Abort in the second ON window
      cfg_write(8'h81, 32'd3);
      cfg_write(8'h82, 32'd2);
      cfg_write(8'h83, 32'd3);
      do_commit();
      arm = 1'b1;
      step();
      arm = 1'b0;
      ext_trigger = 1'b1;
      step();
      step();
      check("abort.on1", 256'(ch_trigger), 256'(8'hFF));
      repeat (3) step();
      check("abort.off1", 256'(ch_trigger), 256'(0));
      repeat (2) step();
      check("abort.on2", 256'(ch_trigger), 256'(8'hFF));
      abort = 1'b1;
      step();
      abort = 1'b0;
      ext_trigger = 1'b0;
      check("abort.trig_drop", 256'(ch_trigger), 256'(0));
      check("abort.idle", 256'(busy), 256'(0));
      check("abort.no_done", 256'(done), 256'(0));
      step();
      check("abort.no_late_done", 256'({done, busy}), 256'(0));
      run_burst("after_abort", 8'hFF, 3, 2, 3, -1, 1'b0, 32'h123, 32'h123);
      run_burst("retrig", 8'hFF, 3, 2, 3, -1, 1'b1, 32'h123, 32'h123);

      cfg_write(8'h81, 32'd0);
      cfg_write(8'h82, 32'd0);
      cfg_write(8'h83, 32'd0);
      do_commit();
      run_burst("zero", 8'hFF, 0, 0, 0, -1, 1'b0, 32'h123, 32'h123);

      // Reset during ON with a commit queued
      cfg_write(8'h81, 32'd5);
      do_commit();
      arm = 1'b1;
      step();
      arm = 1'b0;
      ext_trigger = 1'b1;
      commit = 1'b1;
      step();
      commit = 1'b0;
      check("rst_run.pending", 256'(commit_pending), 256'(1));
      step();
      check("rst_run.on", 256'(ch_trigger), 256'(8'hFF));
      reset = 1'b1;
      step();
      check("rst_run.trig", 256'(ch_trigger), 256'(0));
      check("rst_run.flags", 256'({busy, done, commit_pending, cfg_if.cfg_ready}), 256'(0));
      check("rst_run.ch_dl", 256'(ch_dl), 256'(0));
      check("rst_run.ch_wb", 256'(ch_wb), 256'(0));
      ext_trigger = 1'b0;
      reset = 1'b0;
      step();
      check("rst_run.cfg_ready", 256'(cfg_if.cfg_ready), 256'(1));
      // on/off/shots are back to 1, so only the mask needs writing
      cfg_write(8'h80, 32'h01);
      do_commit();
      run_burst("post_reset", 8'h01, 1, 1, 1, -1, 1'b0, 32'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
